// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator CPU: opcodes, UAL operation
// selects and the control-unit state encoding.
package cpu_pkg;

    localparam logic [2:0] OP_NOR = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_STA = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JCC = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    // UAL_IDLE yields result 0 and carry 0; it is the select outside S_ALU
    localparam logic [2:0] UAL_NOR  = 3'b000;
    localparam logic [2:0] UAL_IDLE = 3'b001;
    localparam logic [2:0] UAL_ADD  = 3'b010;
    localparam logic [2:0] UAL_SUB  = 3'b011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_OPRD   = 3'd2,
        S_EXEC   = 3'd3,
        S_ALU    = 3'd4,
        S_STORE  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    function automatic logic [2:0] opcode_of(input logic [15:0] word);
        return word[15:13];
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: synchronous reset to RESET_PC, then load or increment
// (wrapping modulo 2^ADDR_W) on CE-qualified edges.
module pc_counter #(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_r;

    // PC register; load has priority over increment
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else if (ce) begin
            if (load) begin
                pc_r <= load_val;
            end else if (inc) begin
                pc_r <= pc_r + ADDR_W'(1'b1);
            end else begin
                pc_r <= pc_r;
            end
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/unite_controle.sv
// Control unit of the 16-bit accumulator CPU: fetch/decode FSM sequencing the
// memory, R1/ACCU loads and the UAL. Owns IR and the carry flag.
module unite_controle
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CE,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [15:0]       mem_rdata,
    output logic              load_r1,
    output logic              load_accu,
    output logic              accu_src,
    output logic [2:0]        sel_UAL,
    input  logic              ual_carry,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    state_t            state_r, next_state_s;
    logic [2:0]        ir_op_r, ir_op_next_s;
    logic [ADDR_W-1:0] ir_addr_r, ir_addr_next_s;
    logic              carry_r, carry_next_s;
    logic              pc_load_s, pc_inc_s;
    logic              rd_s, wr_s, r1_s, acc_s;
    logic              strobe_en_s;
    logic [2:0]        dec_op_s;
    logic              unused_rdata_s;

    // Bits between the opcode and the address field carry no meaning
    assign unused_rdata_s = ^mem_rdata;
    assign dec_op_s       = opcode_of(mem_rdata);

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_counter (
        .clk      (clk),
        .reset    (reset),
        .ce       (CE),
        .load     (pc_load_s),
        .inc      (pc_inc_s),
        .load_val (mem_rdata[ADDR_W-1:0]),
        .pc       (pc)
    );

    // State, IR and carry registers; everything holds while CE is low
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_FETCH;
            ir_op_r   <= 3'b000;
            ir_addr_r <= {ADDR_W{1'b0}};
            carry_r   <= 1'b0;
        end else if (CE) begin
            state_r   <= next_state_s;
            ir_op_r   <= ir_op_next_s;
            ir_addr_r <= ir_addr_next_s;
            carry_r   <= carry_next_s;
        end else begin
            state_r   <= state_r;
            ir_op_r   <= ir_op_r;
            ir_addr_r <= ir_addr_r;
            carry_r   <= carry_r;
        end
    end

    // Next-state logic and Moore output decode
    always_comb begin
        next_state_s   = state_r;
        ir_op_next_s   = ir_op_r;
        ir_addr_next_s = ir_addr_r;
        carry_next_s   = carry_r;
        pc_load_s      = 1'b0;
        pc_inc_s       = 1'b0;
        rd_s           = 1'b0;
        wr_s           = 1'b0;
        r1_s           = 1'b0;
        acc_s          = 1'b0;
        accu_src       = 1'b0;
        sel_UAL        = UAL_IDLE;
        halted         = 1'b0;
        mem_addr       = pc;
        case (state_r)
            S_FETCH: begin
                rd_s         = 1'b1;
                next_state_s = S_DECODE;
            end
            S_DECODE: begin
                ir_op_next_s   = dec_op_s;
                ir_addr_next_s = mem_rdata[ADDR_W-1:0];
                pc_inc_s       = 1'b1;
                case (dec_op_s)
                    OP_HLT: next_state_s = S_HALT;
                    OP_JMP: begin
                        pc_load_s    = 1'b1;
                        next_state_s = S_FETCH;
                    end
                    OP_JCC: begin
                        // taken only when carry is clear; carry is consumed either way
                        if (!carry_r) begin
                            pc_load_s = 1'b1;
                        end else begin
                            pc_load_s = 1'b0;
                        end
                        carry_next_s = 1'b0;
                        next_state_s = S_FETCH;
                    end
                    OP_STA:  next_state_s = S_STORE;
                    default: next_state_s = S_OPRD;
                endcase
            end
            S_OPRD: begin
                mem_addr     = ir_addr_r;
                rd_s         = 1'b1;
                next_state_s = S_EXEC;
            end
            S_EXEC: begin
                if (ir_op_r == OP_LDA) begin
                    acc_s        = 1'b1;
                    accu_src     = 1'b1;
                    next_state_s = S_FETCH;
                end else begin
                    r1_s         = 1'b1;
                    next_state_s = S_ALU;
                end
            end
            S_ALU: begin
                sel_UAL      = ir_op_r;
                acc_s        = 1'b1;
                carry_next_s = ual_carry;
                next_state_s = S_FETCH;
            end
            S_STORE: begin
                mem_addr     = ir_addr_r;
                wr_s         = 1'b1;
                next_state_s = S_FETCH;
            end
            S_HALT: begin
                halted       = 1'b1;
                next_state_s = S_HALT;
            end
            default: next_state_s = S_FETCH;
        endcase
    end

    // Strobes are suppressed on stalled cycles and on the reset edge
    assign strobe_en_s = CE & ~reset;
    assign mem_rd      = rd_s  & strobe_en_s;
    assign mem_wr      = wr_s  & strobe_en_s;
    assign load_r1     = r1_s  & strobe_en_s;
    assign load_accu   = acc_s & strobe_en_s;

endmodule

// File: tb/tb_unite_controle.sv
// Bench for unite_controle: bench-side memory, R1/ACCU and UAL close the loop;
// an instruction-level reference model feeds a scoreboard of expected bus events.
module tb_unite_controle;

    localparam int EV_RD  = 0;
    localparam int EV_WR  = 1;
    localparam int EV_R1  = 2;
    localparam int EV_ACC = 3;

    typedef struct {
        int kind;
        int addr;
        int data;
        int gap;
        int src;
        int sel;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        CE = 1'b1;
    logic [7:0]  mem_addr;
    logic        mem_rd, mem_wr, load_r1, load_accu, accu_src, ual_carry, halted;
    logic [15:0] mem_rdata = 16'h0000;
    logic [2:0]  sel_UAL;
    logic [7:0]  pc;

    logic [15:0] mem [0:255];
    logic [15:0] r1, accu, ual_out;
    logic [16:0] ual_sum;

    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    bit   mon_en = 1'b0;
    int   ce_cnt = 0;

    int   ref_mem [0:255];
    bit   model_halted;

    always #5 clk = ~clk;

    unite_controle dut (
        .clk       (clk),
        .reset     (reset),
        .CE        (CE),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .load_r1   (load_r1),
        .load_accu (load_accu),
        .accu_src  (accu_src),
        .sel_UAL   (sel_UAL),
        .ual_carry (ual_carry),
        .pc        (pc),
        .halted    (halted)
    );

    // Synchronous single-port memory sharing the clock enable
    always @(posedge clk) begin
        if (CE) begin
            if (mem_wr) mem[mem_addr] = accu;
            if (mem_rd) mem_rdata <= mem[mem_addr];
        end
    end

    // Datapath registers
    always @(posedge clk) begin
        if (reset) begin
            r1   <= 16'h0000;
            accu <= 16'h0000;
        end else if (CE) begin
            if (load_r1)   r1   <= mem_rdata;
            if (load_accu) accu <= accu_src ? mem_rdata : ual_out;
        end
    end

    // UAL: ACCU op R1; SUB carry is the borrow
    always_comb begin
        ual_sum = 17'h00000;
        case (sel_UAL)
            3'b000:  ual_sum = {1'b0, ~(accu | r1)};
            3'b010:  ual_sum = {1'b0, accu} + {1'b0, r1};
            3'b011:  ual_sum = {1'b0, accu} - {1'b0, r1};
            default: ual_sum = 17'h00000;
        endcase
    end
    assign ual_out   = ual_sum[15:0];
    assign ual_carry = ual_sum[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] strobes();
        return {mem_rd, mem_wr, load_r1, load_accu};
    endfunction

    task automatic push(input int kind, input int addr, input int data, input int gap,
                        input int src, input int sel);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.gap = gap; e.src = src; e.sel = sel;
        exp_q.push_back(e);
    endtask

    // Instruction-level model: executes up to `limit` instructions from address 0
    task automatic run_model(input int limit);
        int rpc, racc, rr1, rcarry, gap, ir, op, a, s;
        rpc = 0; racc = 0; rr1 = 0; rcarry = 0; gap = 0;
        model_halted = 1'b0;
        for (int n = 0; n < limit; n++) begin
            push(EV_RD, rpc, 0, gap, 0, 0);
            ir  = ref_mem[rpc];
            op  = ir / 8192;
            a   = ir % 256;
            rpc = (rpc + 1) % 256;
            if (op == 7) begin
                model_halted = 1'b1;
                break;
            end else if (op == 5) begin
                rpc = a; gap = 2;
            end else if (op == 6) begin
                if (rcarry == 0) rpc = a;
                rcarry = 0; gap = 2;
            end else if (op == 4) begin
                push(EV_WR, a, racc, 2, 0, 0);
                ref_mem[a] = racc; gap = 1;
            end else if (op == 1) begin
                push(EV_RD, a, 0, 2, 0, 0);
                racc = ref_mem[a];
                push(EV_ACC, 0, racc, 1, 1, 0);
                gap = 1;
            end else begin
                push(EV_RD, a, 0, 2, 0, 0);
                rr1 = ref_mem[a];
                push(EV_R1, 0, rr1, 1, 0, 0);
                if (op == 2) begin
                    s = racc + rr1;
                    rcarry = (s > 65535) ? 1 : 0;
                    racc = s % 65536;
                end else if (op == 3) begin
                    rcarry = (racc < rr1) ? 1 : 0;
                    racc = (racc - rr1 + 65536) % 65536;
                end else begin
                    rcarry = 0;
                    racc = 65535 - (racc | rr1);
                end
                push(EV_ACC, 0, racc, 1, 0, op);
                gap = 1;
            end
        end
    endtask

    // Monitor: pops one expected event per CE-qualified strobe cycle
    always @(negedge clk) begin
        ev_t e;
        int  kind, data;
        if (reset) begin
            ce_cnt = 0;
        end else if (!CE) begin
            if (mon_en) chk("stall_quiet", {28'h0, strobes()}, 32'h0);
        end else if (mon_en && (strobes() != 4'b0000)) begin
            chk("one_strobe", int'(mem_rd) + int'(mem_wr) + int'(load_r1) + int'(load_accu), 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {28'h0, strobes()}, 32'h0);
            end else begin
                e    = exp_q.pop_front();
                kind = mem_rd ? EV_RD : mem_wr ? EV_WR : load_r1 ? EV_R1 : EV_ACC;
                chk("ev_kind", kind, e.kind);
                chk("ev_gap", ce_cnt, e.gap);
                if (kind == EV_RD || kind == EV_WR) chk("ev_addr", mem_addr, e.addr);
                if (kind == EV_WR) chk("ev_wdata", accu, e.data);
                if (kind == EV_R1) chk("ev_r1", mem_rdata, e.data);
                if (kind == EV_ACC) begin
                    data = accu_src ? mem_rdata : ual_out;
                    chk("ev_accu", data, e.data);
                    chk("ev_src", accu_src, e.src);
                    if (e.src == 0) chk("ev_sel", sel_UAL, e.sel);
                end
            end
            ce_cnt = 1;
        end else begin
            ce_cnt++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench sampling cycle 0 (first S_FETCH) with reset released
    task automatic do_reset();
        CE = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    logic [3:0] t5_str  [0:9] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                  4'b1000, 4'b0010, 4'b0001, 4'b1000, 4'b0000};
    logic [7:0] t5_addr [0:9] = '{8'h00, 8'h00, 8'h07, 8'h07, 8'h07,
                                  8'h07, 8'h01, 8'h01, 8'h01, 8'h01};

    initial begin
        int cyc;
        bit found;

        // HLT straight out of reset
        clear_mem();
        mem[0] = 16'hE000;
        do_reset();
        chk("t1_rd", mem_rd, 1'b1);
        chk("t1_addr", mem_addr, 8'h00);
        chk("t1_accu_src", accu_src, 1'b0);
        chk("t1_sel_idle", sel_UAL, 3'b001);
        next_cycle();
        chk("t1_decode_not_halted", halted, 1'b0);
        next_cycle();
        chk("t1_halted", halted, 1'b1);
        chk("t1_quiet", strobes(), 4'b0000);
        repeat (3) next_cycle();
        chk("t1_still_halted", halted, 1'b1);
        chk("t1_still_quiet", strobes(), 4'b0000);
        chk("t1_pc", pc, 8'h01);

        // LDA, ADD with carry, JCC not taken then taken
        clear_mem();
        mem[0] = 16'h2005; mem[5] = 16'h0003;
        mem[1] = 16'h4006; mem[6] = 16'hFFFF;
        mem[2] = 16'hC040; mem[3] = 16'hC040; mem[8'h40] = 16'hE000;
        do_reset();
        for (int i = 0; i <= 15; i++) begin
            if (i == 3) begin
                chk("t2_lda_load", load_accu, 1'b1);
                chk("t2_lda_src", accu_src, 1'b1);
            end
            if (i == 7) chk("t2_add_r1", load_r1, 1'b1);
            if (i == 8) begin
                chk("t2_add_sel", sel_UAL, 3'b010);
                chk("t2_add_load", load_accu, 1'b1);
                chk("t2_add_src", accu_src, 1'b0);
                chk("t2_add_pc", pc, 8'h02);
            end
            if (i == 9) begin
                chk("t2_accu", accu, 16'h0002);
                chk("t3_fetch_jcc1", mem_addr, 8'h02);
            end
            if (i == 11) chk("t3_jcc_not_taken", mem_addr, 8'h03);
            if (i == 13) chk("t3_jcc_taken", mem_addr, 8'h40);
            if (i == 15) chk("t3_halted", halted, 1'b1);
            next_cycle();
        end

        // STA: single write cycle at the operand address
        clear_mem();
        mem[0] = 16'h8020; mem[1] = 16'hE000; mem[8'h20] = 16'h1234;
        do_reset();
        next_cycle();
        next_cycle();
        chk("t4_wr", strobes(), 4'b0100);
        chk("t4_addr", mem_addr, 8'h20);
        next_cycle();
        chk("t4_next_fetch", strobes(), 4'b1000);
        chk("t4_fetch_addr", mem_addr, 8'h01);
        chk("t4_written", mem[8'h20], 16'h0000);

        // SUB with CE low for three cycles in S_OPRD
        clear_mem();
        mem[0] = 16'h6007; mem[7] = 16'h0001; mem[1] = 16'hE000;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            CE = (i >= 2 && i < 5) ? 1'b0 : 1'b1;
            #1;
            chk("t5_strobes", strobes(), t5_str[i]);
            chk("t5_addr", mem_addr, t5_addr[i]);
            if (i == 7) chk("t5_sel", sel_UAL, 3'b011);
            next_cycle();
        end
        chk("t5_accu", accu, 16'hFFFF);

        // PC wrap, then reset in S_ALU suppresses the ACCU load
        clear_mem();
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (mem_rd && mem_addr == 8'hFF) found = 1'b1;
            else next_cycle();
        end
        chk("t6_reach_ff", found, 1'b1);
        repeat (5) next_cycle();
        chk("t6_wrap_rd", mem_rd, 1'b1);
        chk("t6_wrap_addr", mem_addr, 8'h00);
        repeat (4) next_cycle();
        mem[0] = 16'hC040; mem[8'h40] = 16'hE000;
        reset = 1'b1;
        #1;
        chk("t6_reset_no_load", load_accu, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_after_reset_rd", mem_rd, 1'b1);
        chk("t6_after_reset_pc", pc, 8'h00);
        next_cycle();
        next_cycle();
        chk("t6_carry_cleared_jcc", mem_addr, 8'h40);

        // Randomized programs with random clock-enable against the model
        for (int run = 0; run < 8; run++) begin
            for (int i = 0; i < 256; i++) begin
                logic [2:0] op;
                op = ($urandom_range(0, 99) < 3) ? 3'b111 : 3'($urandom_range(0, 6));
                mem[i] = (i >= 128 && $urandom_range(0, 1) == 1) ? 16'($urandom)
                                                                   : {op, 5'($urandom), 8'($urandom)};
                ref_mem[i] = int'(mem[i]);
            end
            exp_q.delete();
            run_model(40);
            do_reset();
            mon_en = 1'b1;
            cyc = 0;
            while (exp_q.size() > 0 && cyc < 3000) begin
                @(posedge clk);
                #1;
                CE = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
                cyc++;
            end
            chk("rand_drained", exp_q.size(), 0);
            if (model_halted) begin
                CE = 1'b1;
                repeat (4) next_cycle();
                chk("rand_halted", halted, 1'b1);
            end
            mon_en = 1'b0;
            exp_q.delete();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
